div_result_buffer: RTL and testbench
====================================

// Module: div_result_buffer
// PURPOSE
//  Buffers completions from the pipelined 32-bit divider, which cannot stall, and
//  presents them to the result/CDB arbiter over a valid/ready handshake.
//  Issues credits upstream so the dispatch logic never starts more divides than
//  the buffer can absorb: buffered entries + in-flight divides <= DEPTH.
//  Sits directly downstream of the divider and in parallel with its start input.
// PARAMETERS
//  DEPTH    8   result FIFO entries (power of 2, >= 2)
//  PTR_W    3   log2(DEPTH)
//  CNT_W    4   width of occupancy/in-flight counters (holds 0..DEPTH)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high
//  issue_valid    in   1   dispatch pulses divider start this cycle
//  issue_ready    out  1   credit available; dispatch may start a divide
//  div_done       in   1   divider result valid this cycle
//  div_result     in   32  quotient/remainder selected by divider
//  div_phys_addr  in   8   destination physical register
//  div_pc         in   32  PC of the divide instruction
//  div_dz_exc     in   1   divide-by-zero flag
//  out_valid      out  1   head entry valid
//  out_ready      in   1   arbiter accepts head this cycle
//  out_result     out  32  head result
//  out_phys_addr  out  8   head destination register
//  out_pc         out  32  head PC
//  out_dz_exc     out  1   head divide-by-zero flag
//  occupancy      out  CNT_W  entries currently buffered
//  overflow_err   out  1   sticky: div_done arrived while FIFO full
// BEHAVIOUR
//  Reset: all outputs 0 except issue_ready=1 after the first clock with reset
//  low; counters 0, pointers 0, overflow_err 0. Reset is shared with the
//  divider, so in-flight work is discarded on both sides consistently.
//  Credit: issue_ready = (inflight + occupancy) < DEPTH, combinational from regs.
//  - issue accepted = issue_valid & issue_ready -> inflight+1 next cycle.
//  - issue_valid while !issue_ready is a dispatch bug: ignored, not counted.
//  - div_done -> inflight-1. Accept and done in the same cycle leaves inflight unchanged.
//  - div_done with inflight==0 is ignored for the counter (saturates at 0).
//  FIFO write: on div_done, write {result,phys_addr,pc,dz_exc} at wr_ptr and
//  increment wr_ptr (mod DEPTH) and occupancy.
//  FIFO read: pop = out_valid & out_ready; rd_ptr+1 (mod DEPTH), occupancy-1.
//  Push and pop in the same cycle: occupancy unchanged; legal when full
//  (pop frees the slot) and when empty (no bypass, see latency).
//  Full with div_done and no pop: entry dropped, pointers unchanged,
//  overflow_err set until reset. Unreachable if the credit rule is obeyed.
//  Output: out_valid = (occupancy != 0); out_* driven from the head entry.
//  out_* held stable while out_valid & !out_ready.
//  Latency: div_done in cycle N -> out_valid in N+1 (no combinational bypass).
//  Pop in cycle N -> next entry presented in N+1 if present.
//  Order: strict FIFO; the divider completes in issue order.
//  Widths: counters are CNT_W bits; inflight+occupancy is summed at CNT_W+1
//  bits so the compare cannot wrap.
// TESTING
//  1 reset, then single divide: issue, div_done result=0x7 pa=0x12 pc=0x100 ->
//    out_valid next cycle with same fields; pop -> occupancy 0, issue_ready 1.
//  2 DEPTH=8, out_ready=0: 8 issues accepted, 9th sees issue_ready=0; after 8
//    div_done, occupancy=8; one pop -> issue_ready=1 the cycle after.
//  3 Streaming: issue every cycle, out_ready=1 -> results in issue order,
//    occupancy stays <=1, issue_ready never drops.
//  4 Full FIFO + simultaneous div_done and pop -> occupancy stays 8, no drop,
//    overflow_err=0; forced div_done when full without pop -> overflow_err=1.
//  5 Back-pressure: out_ready toggles 0/1 -> out_* stable while stalled, no loss
//    or duplication; dz_exc=1 entry (div by 0) propagates with pc intact.
//  6 Reset asserted with 3 in flight and 2 buffered -> next cycle out_valid=0,
//    occupancy=0, issue_ready=1, overflow_err=0.

Source files
------------

// File: rtl/div_result_buffer.sv
// Result FIFO behind the non-stallable pipelined divider, with a credit counter
// that keeps buffered entries plus in-flight divides from exceeding DEPTH.
module div_result_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic              div_done,
   input  logic [31:0]       div_result,
   input  logic [7:0]        div_phys_addr,
   input  logic [31:0]       div_pc,
   input  logic              div_dz_exc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic [7:0]        out_phys_addr,
   output logic [31:0]       out_pc,
   output logic              out_dz_exc,
   output logic [CNT_W-1:0]  occupancy,
   output logic              overflow_err
);

   typedef struct packed {
      logic [31:0] result;
      logic [7:0]  phys_addr;
      logic [31:0] pc;
      logic        dz_exc;
   } entry_t;

   localparam logic [CNT_W:0]   SUM_LIMIT = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];

   logic [CNT_W:0]   credit_sum;
   logic             accept;
   logic             retire;
   logic             full;
   logic             pop;
   logic             push;
   entry_t           head;

   always_comb begin
      // Summed one bit wider than the counters so the credit compare cannot wrap.
      credit_sum  = {1'b0, inflight_q} + {1'b0, occ_q};
      issue_ready = (credit_sum < SUM_LIMIT);
      accept      = issue_valid & issue_ready;
      retire      = div_done & (inflight_q != '0);
      full        = (occ_q == CNT_FULL);
      out_valid   = (occ_q != '0);
      pop         = out_valid & out_ready;
      push        = div_done & (~full | pop);

      inflight_d = inflight_q;
      if (accept & ~retire) begin
         inflight_d = inflight_q + CNT_W'(1);
      end else if (~accept & retire) begin
         inflight_d = inflight_q - CNT_W'(1);
      end

      occ_d = occ_q;
      if (push & ~pop) begin
         occ_d = occ_q + CNT_W'(1);
      end else if (~push & pop) begin
         occ_d = occ_q - CNT_W'(1);
      end

      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      overflow_d = overflow_q | (div_done & full & ~pop);

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{result: div_result, phys_addr: div_phys_addr,
                             pc: div_pc, dz_exc: div_dz_exc};
      end

      // Head fields read as zero when empty so stale slots never leak out.
      head          = out_valid ? mem_q[rd_ptr_q] : '0;
      out_result    = head.result;
      out_phys_addr = head.phys_addr;
      out_pc        = head.pc;
      out_dz_exc    = head.dz_exc;
      occupancy     = occ_q;
      overflow_err  = overflow_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q <= '0;
         occ_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_div_result_buffer.sv
// Directed checks of the divider result buffer: credit accounting, FIFO order,
// full/overflow corners, back-pressure stability and mid-flight reset.
module tb_div_result_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic        div_done;
   logic [31:0] div_result;
   logic [7:0]  div_phys_addr;
   logic [31:0] div_pc;
   logic        div_dz_exc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [7:0]  out_phys_addr;
   logic [31:0] out_pc;
   logic        out_dz_exc;
   logic [3:0]  occupancy;
   logic        overflow_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_result_buffer #(.DEPTH(8), .PTR_W(3), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .div_done(div_done), .div_result(div_result), .div_phys_addr(div_phys_addr),
      .div_pc(div_pc), .div_dz_exc(div_dz_exc),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_phys_addr(out_phys_addr), .out_pc(out_pc), .out_dz_exc(out_dz_exc),
      .occupancy(occupancy), .overflow_err(overflow_err)
   );

   typedef struct {
      logic        iv;
      logic        dd;
      logic [31:0] res;
      logic [7:0]  pa;
      logic [31:0] pc;
      logic        dz;
      logic        ordy;
      logic        e_valid;
      logic        e_ready;
      logic [3:0]  e_occ;
      logic [31:0] e_res;
      logic [7:0]  e_pa;
      logic [31:0] e_pc;
      logic        e_dz;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] drain_exp [8];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge and outputs are sampled there too.
   task automatic apply_stimulus(input logic iv, input logic dd, input logic [31:0] res,
                                 input logic [7:0] pa, input logic [31:0] pc,
                                 input logic dz, input logic ordy);
      issue_valid   = iv;
      div_done      = dd;
      div_result    = res;
      div_phys_addr = pa;
      div_pc        = pc;
      div_dz_exc    = dz;
      out_ready     = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      apply_stimulus(1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, ordy);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      int e;
      int exp_k;
      logic [15:0] ready_pat;
      logic        was_valid;

      reset = 1'b1;
      issue_valid = 1'b0; div_done = 1'b0; div_result = '0; div_phys_addr = '0;
      div_pc = '0; div_dz_exc = 1'b0; out_ready = 1'b0;
      #1;
      idle(1'b0);
      check_output("rst_out_valid", 32'(out_valid), 32'h0);
      check_output("rst_occupancy", 32'(occupancy), 32'h0);
      check_output("rst_overflow", 32'(overflow_err), 32'h0);
      check_output("rst_out_result", out_result, 32'h0);
      reset = 1'b0;
      idle(1'b0);
      check_output("rst_issue_ready", 32'(issue_ready), 32'h1);

      // Single divide, inflight saturation at zero, and same-cycle push/pop.
      vecs[0] = '{1'b1, 1'b0, 32'h0,  8'h00, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0,  8'h00, 32'h000, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h7,  8'h12, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h7,  8'h12, 32'h100, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h0,  8'h00, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  8'h00, 32'h000, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h55, 8'h01, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h55, 8'h01, 32'h200, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h0,  8'h00, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  8'h00, 32'h000, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 32'h9,  8'h03, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h9,  8'h03, 32'h300, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 32'hA,  8'h04, 32'h304, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 32'hA,  8'h04, 32'h304, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 32'h0,  8'h00, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,  8'h00, 32'h000, 1'b0};
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].iv, vecs[i].dd, vecs[i].res, vecs[i].pa, vecs[i].pc,
                        vecs[i].dz, vecs[i].ordy);
         check_output($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
         check_output($sformatf("vec%0d_issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_ready));
         check_output($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
         if (vecs[i].e_valid) begin
            check_output($sformatf("vec%0d_result", i), out_result, vecs[i].e_res);
            check_output($sformatf("vec%0d_phys_addr", i), 32'(out_phys_addr), 32'(vecs[i].e_pa));
            check_output($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
            check_output($sformatf("vec%0d_dz", i), 32'(out_dz_exc), 32'(vecs[i].e_dz));
         end
      end

      // Credit exhaustion with the arbiter stalled.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         check_output($sformatf("fill_credit%0d", i), 32'(issue_ready), 32'h1);
         apply_stimulus(1'b1, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
      end
      check_output("fill_no_credit", 32'(issue_ready), 32'h0);
      apply_stimulus(1'b1, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b0, 1'b1, 32'h2000 + 32'(i), 8'h20 + 8'(i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
      end
      check_output("fill_occupancy", 32'(occupancy), 32'd8);
      check_output("fill_full_credit", 32'(issue_ready), 32'h0);
      check_output("fill_head", out_result, 32'h2000);
      idle(1'b1);
      check_output("pop_occupancy", 32'(occupancy), 32'd7);
      check_output("pop_credit_back", 32'(issue_ready), 32'h1);
      check_output("pop_next_head", out_result, 32'h2001);

      // Full FIFO: push with pop is legal, push without pop drops and flags.
      apply_stimulus(1'b1, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
      check_output("refill_credit", 32'(issue_ready), 32'h0);
      apply_stimulus(1'b0, 1'b1, 32'h3000, 8'h30, 32'h5000, 1'b0, 1'b0);
      check_output("refill_occupancy", 32'(occupancy), 32'd8);
      apply_stimulus(1'b0, 1'b1, 32'h3001, 8'h31, 32'h5004, 1'b0, 1'b1);
      check_output("full_pushpop_occ", 32'(occupancy), 32'd8);
      check_output("full_pushpop_ovf", 32'(overflow_err), 32'h0);
      check_output("full_pushpop_head", out_result, 32'h2002);
      apply_stimulus(1'b0, 1'b1, 32'h3002, 8'h32, 32'h5008, 1'b0, 1'b0);
      check_output("overflow_set", 32'(overflow_err), 32'h1);
      check_output("overflow_occ", 32'(occupancy), 32'd8);
      for (int i = 0; i < 6; i++) drain_exp[i] = 32'h2002 + 32'(i);
      drain_exp[6] = 32'h3000;
      drain_exp[7] = 32'h3001;
      for (int i = 0; i < 8; i++) begin
         check_output($sformatf("drain%0d", i), out_result, drain_exp[i]);
         idle(1'b1);
      end
      check_output("drain_empty_valid", 32'(out_valid), 32'h0);
      check_output("drain_empty_occ", 32'(occupancy), 32'd0);
      check_output("overflow_sticky", 32'(overflow_err), 32'h1);

      // Reset with 3 divides in flight and 2 results buffered.
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b1, 32'h6000 + 32'(i), 8'h60, 32'h7000, 1'b0, 1'b0);
      check_output("pre_reset_occ", 32'(occupancy), 32'd2);
      reset = 1'b1;
      idle(1'b0);
      check_output("midrst_out_valid", 32'(out_valid), 32'h0);
      check_output("midrst_occ", 32'(occupancy), 32'd0);
      check_output("midrst_credit", 32'(issue_ready), 32'h1);
      check_output("midrst_overflow", 32'(overflow_err), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
      check_output("midrst_full_credit", 32'(issue_ready), 32'h0);

      // Streaming: divider latency of 3, arbiter always ready.
      do_reset();
      exp_k = 0;
      for (int c = 0; c < 16; c++) begin
         apply_stimulus(c < 10, (c >= 3) && (c < 13), 32'h1000 + 32'(c - 3), 8'h40,
                        32'h9000 + 32'(4 * (c - 3)), 1'b0, 1'b1);
         check_output($sformatf("stream%0d_credit", c), 32'(issue_ready), 32'h1);
         check_output($sformatf("stream%0d_occ_le1", c), 32'(occupancy <= 4'd1), 32'h1);
         if (out_valid) begin
            check_output($sformatf("stream%0d_result", c), out_result, 32'h1000 + 32'(exp_k));
            check_output($sformatf("stream%0d_pc", c), out_pc, 32'h9000 + 32'(4 * exp_k));
            exp_k++;
         end
      end
      check_output("stream_count", 32'(exp_k), 32'd10);

      // Back-pressure: toggling out_ready, entry 2 is a divide-by-zero.
      do_reset();
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b0, 1'b1, 32'h7000 + 32'(i), 8'h70 + 8'(i), 32'h8000 + 32'(4 * i), i == 2, 1'b0);
      end
      ready_pat = 16'b0101_1011_0010_0110;
      e = 0;
      for (int c = 0; c < 16; c++) begin
         check_output($sformatf("bp%0d_valid", c), 32'(out_valid), 32'(e < 4));
         if (out_valid && e < 4) begin
            check_output($sformatf("bp%0d_result", c), out_result, 32'h7000 + 32'(e));
            check_output($sformatf("bp%0d_phys_addr", c), 32'(out_phys_addr), 32'h70 + 32'(e));
            check_output($sformatf("bp%0d_pc", c), out_pc, 32'h8000 + 32'(4 * e));
            check_output($sformatf("bp%0d_dz", c), 32'(out_dz_exc), 32'(e == 2));
         end
         was_valid = out_valid;
         idle(ready_pat[c]);
         if (was_valid && ready_pat[c]) e++;
      end
      check_output("bp_popped", 32'(e), 32'd4);
      check_output("bp_empty_occ", 32'(occupancy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
